// File: rtl/ysyx_24110006_idu.sv
// ysyx_24110006_idu -- RV32I instruction decode stage.
//
// Sits directly after the fetch unit. It takes the fetched instruction word and its PC,
// decodes the RV32I fields, immediate and op class, and holds the result in a one-entry
// pipeline register toward execute. Both sides use a valid/ready handshake. A redirect
// flush discards the held bundle and any incoming one. A free-running counter tracks how
// many bundles execute has accepted.
//
// Build option:
//   YSYX_IDU_RV32E_EN  when defined, any used rs1/rs2/rd index above x15 is illegal
//                      (RV32E). When undefined, all 32 registers are legal. The port
//                      list is the same in both builds.
//
// Ports:
//   i_clock, i_reset_n          clock (rising edge), async active-low reset
//   i_valid/o_ready             fetch handshake; i_inst/i_pc are the payload
//   i_flush                     redirect: drop the held bundle and the incoming instruction
//   o_valid/i_ready             execute handshake for the registered bundle below
//   o_pc, o_inst                registered PC and raw instruction
//   o_opclass                   0 LUI .. 10 MISC_MEM, 15 illegal
//   o_rs1/o_rs2/o_rd (+_en/wen) register indices (0 when unused) and their use flags
//   o_funct3, o_funct7b5        funct3 and inst[30] (OP / shift-immediate only)
//   o_imm                       sign-extended immediate, 0 for R-type
//   o_is_ecall/ebreak/mret      SYSTEM sub-decode
//   o_illegal                   illegal encoding (the bundle is still delivered)
//   o_dec_count                 bundles accepted by execute, wraps
//
// state   | meaning
// --------+------------------------------------------------
// S_EMPTY | no bundle held, o_valid=0
// S_FULL  | bundle held toward execute, o_valid=1

module ysyx_24110006_idu #(
  parameter int XLEN       = 32,
  parameter int PERF_CNT_W = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [31:0]           i_inst,
  input  logic [XLEN-1:0]       i_pc,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [XLEN-1:0]       o_pc,
  output logic [31:0]           o_inst,
  output logic [3:0]            o_opclass,
  output logic [4:0]            o_rs1,
  output logic [4:0]            o_rs2,
  output logic [4:0]            o_rd,
  output logic                  o_rs1_en,
  output logic                  o_rs2_en,
  output logic                  o_rd_wen,
  output logic [2:0]            o_funct3,
  output logic                  o_funct7b5,
  output logic [XLEN-1:0]       o_imm,
  output logic                  o_is_ecall,
  output logic                  o_is_ebreak,
  output logic                  o_is_mret,
  output logic                  o_illegal,
  output logic [PERF_CNT_W-1:0] o_dec_count
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OPIMM    = 7'b0010011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;

  localparam logic [3:0] C_LUI      = 4'd0;
  localparam logic [3:0] C_AUIPC    = 4'd1;
  localparam logic [3:0] C_JAL      = 4'd2;
  localparam logic [3:0] C_JALR     = 4'd3;
  localparam logic [3:0] C_BRANCH   = 4'd4;
  localparam logic [3:0] C_LOAD     = 4'd5;
  localparam logic [3:0] C_STORE    = 4'd6;
  localparam logic [3:0] C_OPIMM    = 4'd7;
  localparam logic [3:0] C_OP       = 4'd8;
  localparam logic [3:0] C_SYSTEM   = 4'd9;
  localparam logic [3:0] C_MISC_MEM = 4'd10;
  localparam logic [3:0] C_ILLEGAL  = 4'd15;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  state_t state, state_nxt;
  logic   load, xfer;

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state <= S_EMPTY;
    else            state <= state_nxt;
  end

  always_comb begin
    o_valid   = (state == S_FULL);
    o_ready   = !o_valid || i_ready;
    load      = i_valid && o_ready && !i_flush;
    xfer      = o_valid && i_ready && !i_flush;
    state_nxt = state;
    if (i_flush)                        state_nxt = S_EMPTY;
    else if (load)                      state_nxt = S_FULL;
    else if (state == S_FULL && i_ready) state_nxt = S_EMPTY;
  end

  // ---------------------------------------------------------------------------
  // Combinational decode of i_inst
  // ---------------------------------------------------------------------------
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd_f, rs1_f, rs2_f;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = i_inst[6:0];
  assign funct3 = i_inst[14:12];
  assign funct7 = i_inst[31:25];
  assign rd_f   = i_inst[11:7];
  assign rs1_f  = i_inst[19:15];
  assign rs2_f  = i_inst[24:20];

  assign imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
  assign imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign imm_u = {i_inst[31:12], 12'b0};
  assign imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

  logic [3:0]  d_opclass;
  logic        use_rd, use_rs1, use_rs2;
  logic [31:0] d_imm;
  logic [2:0]  d_funct3;
  logic        d_funct7b5, d_ecall, d_ebreak, d_mret, d_illegal;

  always_comb begin
    d_opclass  = C_ILLEGAL;
    use_rd     = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    d_imm      = 32'd0;
    d_funct3   = funct3;
    d_funct7b5 = 1'b0;
    d_ecall    = 1'b0;
    d_ebreak   = 1'b0;
    d_mret     = 1'b0;
    d_illegal  = 1'b0;

    // Every legal opcode ends in 2'b11, so compressed/invalid low bits land in default.
    case (opcode)
      OP_LUI: begin
        d_opclass = C_LUI;    use_rd = 1'b1; d_imm = imm_u; d_funct3 = 3'd0;
      end
      OP_AUIPC: begin
        d_opclass = C_AUIPC;  use_rd = 1'b1; d_imm = imm_u; d_funct3 = 3'd0;
      end
      OP_JAL: begin
        d_opclass = C_JAL;    use_rd = 1'b1; d_imm = imm_j; d_funct3 = 3'd0;
      end
      OP_JALR: begin
        d_opclass = C_JALR;   use_rd = 1'b1; use_rs1 = 1'b1; d_imm = imm_i;
        d_illegal = (funct3 != 3'd0);
      end
      OP_BRANCH: begin
        d_opclass = C_BRANCH; use_rs1 = 1'b1; use_rs2 = 1'b1; d_imm = imm_b;
        d_illegal = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      OP_LOAD: begin
        d_opclass = C_LOAD;   use_rd = 1'b1; use_rs1 = 1'b1; d_imm = imm_i;
        d_illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OP_STORE: begin
        d_opclass = C_STORE;  use_rs1 = 1'b1; use_rs2 = 1'b1; d_imm = imm_s;
        d_illegal = (funct3 > 3'd2);
      end
      OP_OPIMM: begin
        d_opclass = C_OPIMM;  use_rd = 1'b1; use_rs1 = 1'b1; d_imm = imm_i;
        // Shift-immediates carry funct7 in the immediate field; only SRAI may set bit 30.
        if (funct3 == 3'd1) begin
          d_funct7b5 = i_inst[30];
          d_illegal  = (funct7 != 7'h00);
        end else if (funct3 == 3'd5) begin
          d_funct7b5 = i_inst[30];
          d_illegal  = (funct7 != 7'h00) && (funct7 != 7'h20);
        end
      end
      OP_OP: begin
        d_opclass  = C_OP;    use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        d_funct7b5 = i_inst[30];
        // funct7=0x20 exists only for SUB and SRA.
        d_illegal  = !((funct7 == 7'h00) ||
                       ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5))));
      end
      OP_SYSTEM: begin
        d_opclass = C_SYSTEM; d_imm = imm_i;
        case (funct3)
          3'd0: begin
            if (i_inst == INST_ECALL)       d_ecall   = 1'b1;
            else if (i_inst == INST_EBREAK) d_ebreak  = 1'b1;
            else if (i_inst == INST_MRET)   d_mret    = 1'b1;
            else                            d_illegal = 1'b1;
          end
          3'd4:                   d_illegal = 1'b1;
          3'd1, 3'd2, 3'd3: begin use_rd = 1'b1; use_rs1 = 1'b1; end
          default:                use_rd = 1'b1; // CSR*I: rs1 field is a zimm, not a register
        endcase
      end
      OP_MISC_MEM: begin
        d_opclass = C_MISC_MEM; d_imm = imm_i;
      end
      default: d_illegal = 1'b1;
    endcase

`ifdef YSYX_IDU_RV32E_EN
    if ((use_rd && rd_f[4]) || (use_rs1 && rs1_f[4]) || (use_rs2 && rs2_f[4]))
      d_illegal = 1'b1;
`endif

    if (d_illegal) begin
      d_opclass  = C_ILLEGAL;
      use_rd     = 1'b0;
      use_rs1    = 1'b0;
      use_rs2    = 1'b0;
      d_imm      = 32'd0;
      d_funct7b5 = 1'b0;
      d_ecall    = 1'b0;
      d_ebreak   = 1'b0;
      d_mret     = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Bundle register toward execute
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_pc        <= '0;
      o_inst      <= '0;
      o_opclass   <= '0;
      o_rs1       <= '0;
      o_rs2       <= '0;
      o_rd        <= '0;
      o_rs1_en    <= 1'b0;
      o_rs2_en    <= 1'b0;
      o_rd_wen    <= 1'b0;
      o_funct3    <= '0;
      o_funct7b5  <= 1'b0;
      o_imm       <= '0;
      o_is_ecall  <= 1'b0;
      o_is_ebreak <= 1'b0;
      o_is_mret   <= 1'b0;
      o_illegal   <= 1'b0;
    end else if (load) begin
      o_pc        <= i_pc;
      o_inst      <= i_inst;
      o_opclass   <= d_opclass;
      o_rs1       <= use_rs1 ? rs1_f : 5'd0;
      o_rs2       <= use_rs2 ? rs2_f : 5'd0;
      o_rd        <= use_rd  ? rd_f  : 5'd0;
      o_rs1_en    <= use_rs1;
      o_rs2_en    <= use_rs2;
      o_rd_wen    <= use_rd && (rd_f != 5'd0);
      o_funct3    <= d_funct3;
      o_funct7b5  <= d_funct7b5;
      o_imm       <= d_imm;
      o_is_ecall  <= d_ecall;
      o_is_ebreak <= d_ebreak;
      o_is_mret   <= d_mret;
      o_illegal   <= d_illegal;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)  o_dec_count <= '0;
    else if (xfer)   o_dec_count <= o_dec_count + 1'b1;
  end

endmodule

// File: tb/tb_ysyx_24110006_idu.sv
module tb_ysyx_24110006_idu;

  logic        i_clock = 1'b0;
  logic        i_reset_n, i_valid, i_flush, i_ready;
  logic [31:0] i_inst, i_pc;
  logic        o_ready, o_valid;
  logic [31:0] o_pc, o_inst, o_imm, o_dec_count;
  logic [3:0]  o_opclass;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic        o_rs1_en, o_rs2_en, o_rd_wen, o_funct7b5;
  logic [2:0]  o_funct3;
  logic        o_is_ecall, o_is_ebreak, o_is_mret, o_illegal;

  always #5 i_clock = ~i_clock;

  ysyx_24110006_idu dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_inst(i_inst), .i_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_pc(o_pc), .o_inst(o_inst), .o_opclass(o_opclass), .o_rs1(o_rs1), .o_rs2(o_rs2),
    .o_rd(o_rd), .o_rs1_en(o_rs1_en), .o_rs2_en(o_rs2_en), .o_rd_wen(o_rd_wen),
    .o_funct3(o_funct3), .o_funct7b5(o_funct7b5), .o_imm(o_imm), .o_is_ecall(o_is_ecall),
    .o_is_ebreak(o_is_ebreak), .o_is_mret(o_is_mret), .o_illegal(o_illegal),
    .o_dec_count(o_dec_count)
  );

  typedef struct {
    logic [31:0] inst, pc, imm;
    logic [3:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  en;    // {rd_wen, rs1_en, rs2_en}
    logic [2:0]  f3;
    logic        f7b5;
    logic [2:0]  sys;   // {ecall, ebreak, mret}
    logic        ill;
    bit          chk_f3;
  } exp_t;

  int     n_cmp = 0;
  int     n_err = 0;
  exp_t   sb_q[$];
  exp_t   cur_exp;
  exp_t   vecs[$];
  logic   m_full = 1'b0;
  logic [31:0] m_cnt = 32'd0;
  logic [31:0] pc_next = 32'h8000_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t vec(input logic [31:0] inst, input logic [3:0] opc,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [2:0] en, input logic [31:0] imm, input logic [2:0] f3,
                               input logic f7b5, input logic [2:0] sys, input bit chk_f3);
    exp_t e;
    e.inst = inst; e.pc = 32'd0; e.opc = opc; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.en = en; e.imm = imm; e.f3 = f3; e.f7b5 = f7b5; e.sys = sys;
    e.ill = (opc == 4'd15); e.chk_f3 = chk_f3;
    return e;
  endfunction

  function automatic exp_t bad(input logic [31:0] inst);
    return vec(inst, 4'd15, 5'd0, 5'd0, 5'd0, 3'b000, 32'd0, 3'd0, 1'b0, 3'b000, 1'b0);
  endfunction

  task automatic cmp_bundle(input exp_t e);
    string t;
    t = $sformatf("[%h]", e.inst);
    chk({"pc", t}, o_pc, e.pc);
    chk({"inst", t}, o_inst, e.inst);
    chk({"opclass", t}, {28'd0, o_opclass}, {28'd0, e.opc});
    chk({"illegal", t}, {31'd0, o_illegal}, {31'd0, e.ill});
    chk({"en", t}, {29'd0, o_rd_wen, o_rs1_en, o_rs2_en}, {29'd0, e.en});
    chk({"sys", t}, {29'd0, o_is_ecall, o_is_ebreak, o_is_mret}, {29'd0, e.sys});
    if (!e.ill) begin
      chk({"idx", t}, {17'd0, o_rd, o_rs1, o_rs2}, {17'd0, e.rd, e.rs1, e.rs2});
      chk({"imm", t}, o_imm, e.imm);
      chk({"f7b5", t}, {31'd0, o_funct7b5}, {31'd0, e.f7b5});
      if (e.chk_f3) chk({"funct3", t}, {29'd0, o_funct3}, {29'd0, e.f3});
    end
  endtask

  // Reference handshake model + scoreboard, evaluated away from the active edge.
  always @(negedge i_clock) begin
    logic ld;
    exp_t dropped;
    if (i_reset_n === 1'b1) begin
      chk("o_valid", {31'd0, o_valid}, {31'd0, m_full});
      chk("o_ready", {31'd0, o_ready}, {31'd0, (!m_full || i_ready)});
      chk("dec_count", o_dec_count, m_cnt);
      if (m_full) begin
        if (sb_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else                  cmp_bundle(sb_q[0]);
      end
      ld = i_valid && (!m_full || i_ready) && !i_flush;
      if (m_full && (i_ready || i_flush) && sb_q.size() > 0) dropped = sb_q.pop_front();
      if (m_full && i_ready && !i_flush) m_cnt = m_cnt + 1;
      if (ld) sb_q.push_back(cur_exp);
      if (i_flush)                 m_full = 1'b0;
      else if (ld)                 m_full = 1'b1;
      else if (m_full && i_ready)  m_full = 1'b0;
    end
  end

  task automatic send(input exp_t e, input logic rdy);
    bit got;
    @(posedge i_clock); #1;
    e.pc    = pc_next;
    pc_next = pc_next + 32'd4;
    cur_exp = e;
    i_inst  = e.inst;
    i_pc    = e.pc;
    i_valid = 1'b1;
    i_ready = rdy;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge i_clock);
      if (o_ready === 1'b1) got = 1'b1;
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge i_clock); #1;
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clock);
    #1;
  endtask

  initial begin
    i_reset_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    i_inst = 32'd0; i_pc = 32'd0;

    vecs.push_back(vec(32'h0050_0093, 4'd7, 5'd1, 5'd0, 5'd0, 3'b110, 32'h5,        3'd0, 1'b0, 3'b000, 1'b1));
    vecs.push_back(vec(32'hFE00_0EE3, 4'd4, 5'd0, 5'd0, 5'd0, 3'b011, 32'hFFFFFFFC, 3'd0, 1'b0, 3'b000, 1'b1));
    vecs.push_back(vec(32'h0010_0073, 4'd9, 5'd0, 5'd0, 5'd0, 3'b000, 32'h1,        3'd0, 1'b0, 3'b010, 1'b1));
    vecs.push_back(bad(32'h0000_4073));
    vecs.push_back(vec(32'h1234_52B7, 4'd0, 5'd5, 5'd0, 5'd0, 3'b100, 32'h12345000, 3'd0, 1'b0, 3'b000, 1'b0));
    vecs.push_back(vec(32'h0020_A423, 4'd6, 5'd0, 5'd1, 5'd2, 3'b011, 32'h8,        3'd2, 1'b0, 3'b000, 1'b1));
    vecs.push_back(vec(32'h4020_81B3, 4'd8, 5'd3, 5'd1, 5'd2, 3'b111, 32'h0,        3'd0, 1'b1, 3'b000, 1'b1));
    vecs.push_back(vec(32'hFF9F_F0EF, 4'd2, 5'd1, 5'd0, 5'd0, 3'b100, 32'hFFFFFFF8, 3'd0, 1'b0, 3'b000, 1'b0));
    vecs.push_back(bad(32'h0000_3003));
    vecs.push_back(vec(32'h0000_0073, 4'd9, 5'd0, 5'd0, 5'd0, 3'b000, 32'h0,        3'd0, 1'b0, 3'b100, 1'b1));
    vecs.push_back(vec(32'h3020_0073, 4'd9, 5'd0, 5'd0, 5'd0, 3'b000, 32'h302,      3'd0, 1'b0, 3'b001, 1'b1));
    vecs.push_back(bad(32'h0050_0090));
    vecs.push_back(vec(32'h4030_D093, 4'd7, 5'd1, 5'd1, 5'd0, 3'b110, 32'h403,      3'd5, 1'b1, 3'b000, 1'b1));
    vecs.push_back(bad(32'h4010_9093));
    vecs.push_back(vec(32'hFFC1_2283, 4'd5, 5'd5, 5'd2, 5'd0, 3'b110, 32'hFFFFFFFC, 3'd2, 1'b0, 3'b000, 1'b1));
    vecs.push_back(vec(32'h0000_0013, 4'd7, 5'd0, 5'd0, 5'd0, 3'b010, 32'h0,        3'd0, 1'b0, 3'b000, 1'b1));
    vecs.push_back(vec(32'h0000_1097, 4'd1, 5'd1, 5'd0, 5'd0, 3'b100, 32'h1000,     3'd0, 1'b0, 3'b000, 1'b0));
`ifdef YSYX_IDU_RV32E_EN
    vecs.push_back(bad(32'h0000_0833));
`else
    vecs.push_back(vec(32'h0000_0833, 4'd8, 5'd16, 5'd0, 5'd0, 3'b111, 32'h0,       3'd0, 1'b0, 3'b000, 1'b1));
`endif

    #2;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_count", o_dec_count, 32'd0);
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_inst", o_inst, 32'd0);
    chk("rst_imm", o_imm, 32'd0);
    chk("rst_fields", {o_opclass, o_rs1, o_rs2, o_rd, o_rs1_en, o_rs2_en, o_rd_wen, o_funct3,
                       o_funct7b5, o_is_ecall, o_is_ebreak, o_is_mret, o_illegal}, 32'd0);
    @(posedge i_clock); #3;
    i_reset_n = 1'b1;

    // Decode table with execute always ready.
    foreach (vecs[i]) send(vecs[i], 1'b1);
    idle(3);

    // Back-pressure: A held for 3 cycles, then B offered as execute frees up.
    send(vecs[0], 1'b0);
    idle(3);
    send(vecs[6], 1'b1);
    idle(3);

    // Flush while FULL with a concurrent incoming instruction.
    send(vecs[1], 1'b0);
    cur_exp = vecs[4];
    i_inst  = vecs[4].inst;
    i_pc    = 32'hDEAD_0000;
    i_valid = 1'b1;
    i_flush = 1'b1;
    i_ready = 1'b1;
    @(posedge i_clock); #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    @(negedge i_clock);
    chk("flush_valid", {31'd0, o_valid}, 32'd0);
    idle(2);

    // Asynchronous reset while FULL.
    send(vecs[2], 1'b0);
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("async_rst_count", o_dec_count, 32'd0);
    m_full = 1'b0;
    m_cnt  = 32'd0;
    sb_q.delete();
    @(posedge i_clock); #3;
    i_reset_n = 1'b1;
    i_ready   = 1'b1;
    send(vecs[17], 1'b1);
    idle(3);

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
